// File: rtl/cpu_pkg.sv
// Shared phase codes and sequencer state type for the CPU core control path.
package cpu_pkg;

  localparam logic [1:0] PH_FETCH = 2'b00;
  localparam logic [1:0] PH_EXEC1 = 2'b10;
  localparam logic [1:0] PH_EXEC2 = 2'b01;
  localparam logic [1:0] PH_IDLE  = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_HALT,
    S_INT
  } seq_state_t;

endpackage

// File: rtl/retire_counter.sv
// Free-running instruction counter: increment enable, synchronous active-low clear, natural wrap.
module retire_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!clr_n_i) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Master phase sequencer: fetch/exec1/exec2 stepping, halt, interrupt entry and retire count.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sm_extra,
  input  logic                halt_req,
  input  logic                mem_ready,
  input  logic                mul_busy,
  input  logic                irq,
  input  logic                int_en,
  output logic [1:0]          state,
  output logic                int_cycle,
  output logic                int_ack,
  output logic                halted,
  output logic                stall,
  output logic                instr_done,
  output logic [RETIRE_W-1:0] retired
);

  seq_state_t state_q, state_d;
  logic       take_int;

  assign take_int = irq && int_en;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (!mem_ready) stall   = 1'b1;
        else            state_d = S_EXEC1;
      end
      S_EXEC1: begin
        if (mul_busy || !mem_ready) stall   = 1'b1;
        else if (sm_extra)          state_d = S_EXEC2;
        else                        instr_done = 1'b1;
      end
      S_EXEC2: begin
        if (!mem_ready) stall      = 1'b1;
        else            instr_done = 1'b1;
      end
      S_HALT: begin
        if (take_int) state_d = S_INT;
      end
      S_INT:   state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
    // irq/halt are only looked at when an instruction actually retires
    if (instr_done) begin
      if (take_int)      state_d = S_INT;
      else if (halt_req) state_d = S_HALT;
      else               state_d = S_FETCH;
    end
  end

  always_comb begin
    case (state_q)
      S_FETCH: state = PH_FETCH;
      S_EXEC1: state = PH_EXEC1;
      S_EXEC2: state = PH_EXEC2;
      default: state = PH_IDLE;
    endcase
  end

  assign int_cycle = (state_q == S_INT);
  assign int_ack   = (state_q == S_INT);
  assign halted    = (state_q == S_HALT);

  retire_counter #(.W(RETIRE_W)) u_retire (
    .clk     (clk),
    .clr_n_i (reset_n),
    .inc_i   (instr_done),
    .count_o (retired)
  );

endmodule
